// File: rtl/stage2_relu_pool.sv
// -----------------------------------------------------------------------------
// stage2_relu_pool
//
// Purpose:
//   This block takes the stage-2 channel-sum stream, one C3 feature-map pixel
//   per valid cycle, in raster order. For each pixel it adds the per-map bias,
//   saturates the sum and applies ReLU. It then does 2x2 stride-2 max pooling
//   and emits the pooled map in raster order to the stage-3 input buffer.
//
// Pipeline:
//   capture (accepting edge) -> stage A (bias/sat/ReLU) -> stage B (pooling)
//   A pooled result therefore appears two edges after the accepting edge of
//   its completing pixel (odd row, odd col).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         block enable; low clears the block like rst
//   bias_in    signed per-map bias, sampled with each accepted pixel
//   din_valid  din carries a pixel this cycle
//   din        signed channel sum
//   dout_valid pooled pixel valid (one-cycle pulse)
//   dout       pooled value, non-negative (MSB always 0); holds when idle
//   dout_row   pooled row index of dout
//   dout_col   pooled column index of dout
//   frame_done one-cycle pulse with the last pooled pixel of a map
// -----------------------------------------------------------------------------
module stage2_relu_pool #(
    parameter int DATA_W = 12,
    parameter int MAP_W  = 10,
    parameter int MAP_H  = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [DATA_W-1:0]            bias_in,
    input  logic                         din_valid,
    input  logic [DATA_W-1:0]            din,
    output logic                         dout_valid,
    output logic [DATA_W-1:0]            dout,
    output logic [$clog2(MAP_H/2)-1:0]   dout_row,
    output logic [$clog2(MAP_W/2)-1:0]   dout_col,
    output logic                         frame_done
);

    localparam int COL_W  = $clog2(MAP_W);
    localparam int ROW_W  = $clog2(MAP_H);
    localparam int OCOL_W = $clog2(MAP_W/2);
    localparam int OROW_W = $clog2(MAP_H/2);

    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(MAP_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MAP_H - 1);
    localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

    logic clear;
    logic accept;

    assign clear  = rst | ~en;
    assign accept = en & din_valid;

    // ---------------------------------------------------------------------
    // Raster position of the next accepted pixel
    // ---------------------------------------------------------------------
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    always_ff @(posedge clk) begin
        if (clear) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Capture: pixel, its bias and its position on the accepting edge
    // ---------------------------------------------------------------------
    logic              p_valid;
    logic [DATA_W-1:0] p_din;
    logic [DATA_W-1:0] p_bias;
    logic [COL_W-1:0]  p_col;
    logic [ROW_W-1:0]  p_row;

    always_ff @(posedge clk) begin
        if (clear) begin
            p_valid <= 1'b0;
            p_din   <= '0;
            p_bias  <= '0;
            p_col   <= '0;
            p_row   <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_din  <= din;
                p_bias <= bias_in;
                p_col  <= col;
                p_row  <= row;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage A: bias add, positive saturation, ReLU
    // ---------------------------------------------------------------------
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] relu;

    always_comb begin
        sum  = {p_din[DATA_W-1], p_din} + {p_bias[DATA_W-1], p_bias};
        relu = sum[DATA_W-1:0];
        // sum is DATA_W+1 bits wide, so it cannot overflow. Its sign bit
        // marks a negative result. When the sum is non-negative, bit DATA_W-1
        // is set exactly when the sum exceeds the positive maximum.
        if (sum[DATA_W]) begin
            relu = '0;
        end else if (sum[DATA_W-1]) begin
            relu = POS_MAX;
        end
    end

    logic              a_valid;
    logic [DATA_W-1:0] a_val;
    logic [COL_W-1:0]  a_col;
    logic [ROW_W-1:0]  a_row;

    always_ff @(posedge clk) begin
        if (clear) begin
            a_valid <= 1'b0;
            a_val   <= '0;
            a_col   <= '0;
            a_row   <= '0;
        end else begin
            a_valid <= p_valid;
            if (p_valid) begin
                a_val <= relu;
                a_col <= p_col;
                a_row <= p_row;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage B: horizontal max via hold register, vertical max via line buffer
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] linebuf [MAP_W/2];
    logic [OCOL_W-1:0] lb_idx;
    logic [DATA_W-1:0] hmax;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] pooled;
    logic              last_pix;

    always_comb begin
        lb_idx   = OCOL_W'(a_col >> 1);
        hmax     = (a_val > hold) ? a_val : hold;
        lb_rd    = linebuf[lb_idx];
        pooled   = (lb_rd > hmax) ? lb_rd : hmax;
        last_pix = (a_row == LAST_ROW) && (a_col == LAST_COL);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < MAP_W/2; i++) begin
                linebuf[i] <= '0;
            end
        end else if (a_valid && a_col[0] && !a_row[0]) begin
            linebuf[lb_idx] <= hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hold       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_row   <= '0;
            dout_col   <= '0;
            frame_done <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            if (a_valid) begin
                if (!a_col[0]) begin
                    hold <= a_val;
                end else if (a_row[0]) begin
                    dout       <= pooled;
                    dout_valid <= 1'b1;
                    dout_row   <= OROW_W'(a_row >> 1);
                    dout_col   <= OCOL_W'(a_col >> 1);
                    frame_done <= last_pix;
                end
            end
        end
    end

endmodule
